// File: rtl/anim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : anim_sequencer
// Description : Sprite-animation sequencer. Steps a frame index through one
//               of four play modes (loop, one-shot, ping-pong, reverse loop)
//               on qualifying ticks, holding each frame for hold+1 ticks, and
//               emits a registered sprite-ROM address
//               {anim_cur, frame, ram_addr_y, ram_addr_x}.
// Ports       : clk_25, rst (sync, active-high)
//               tick/start/pause                control
//               anim_sel/anim_len/mode/hold     parameters, latched on start
//               ram_addr_x/ram_addr_y           pixel coordinates
//               frame/anim_cur/busy/done        status
//               rom_addr                        sprite-ROM address
// Revision    : 1.0 - initial release
// ============================================================================
module anim_sequencer #(
    parameter int FRAME_W = 4,
    parameter int ANIM_W  = 2,
    parameter int HOLD_W  = 4,
    parameter int ADDR_W  = 8
) (
    input  logic                              clk_25,
    input  logic                              rst,
    input  logic                              tick,
    input  logic                              start,
    input  logic                              pause,
    input  logic [ANIM_W-1:0]                 anim_sel,
    input  logic [FRAME_W-1:0]                anim_len,
    input  logic [1:0]                        mode,
    input  logic [HOLD_W-1:0]                 hold,
    input  logic [ADDR_W-1:0]                 ram_addr_x,
    input  logic [ADDR_W-1:0]                 ram_addr_y,
    output logic [FRAME_W-1:0]                frame,
    output logic [ANIM_W-1:0]                 anim_cur,
    output logic                              busy,
    output logic                              done,
    output logic [ANIM_W+FRAME_W+2*ADDR_W-1:0] rom_addr
);

    localparam logic [1:0] c_MODE_LOOP = 2'b00;
    localparam logic [1:0] c_MODE_ONE  = 2'b01;
    localparam logic [1:0] c_MODE_PING = 2'b10;
    localparam logic [1:0] c_MODE_REV  = 2'b11;

    localparam logic [FRAME_W-1:0] c_F_ZERO = '0;
    localparam logic [FRAME_W-1:0] c_F_ONE  = FRAME_W'(1);
    localparam logic [HOLD_W-1:0]  c_H_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [FRAME_W-1:0]                  frame_q, frame_d;
    logic [ANIM_W-1:0]                   anim_q, anim_d;
    logic [FRAME_W-1:0]                  len_q, len_d;
    logic [1:0]                          mode_q, mode_d;
    logic [HOLD_W-1:0]                   hold_q, hold_d;
    logic [HOLD_W-1:0]                   hold_cnt_q, hold_cnt_d;
    logic                                dir_up_q, dir_up_d;
    logic                                done_q, done_d;
    logic [ANIM_W+FRAME_W+2*ADDR_W-1:0]  rom_addr_q, rom_addr_d;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            anim_q     <= '0;
            len_q      <= '0;
            mode_q     <= c_MODE_LOOP;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            dir_up_q   <= 1'b1;
            done_q     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            anim_q     <= anim_d;
            len_q      <= len_d;
            mode_q     <= mode_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            dir_up_q   <= dir_up_d;
            done_q     <= done_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        anim_d     = anim_q;
        len_d      = len_q;
        mode_d     = mode_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        dir_up_d   = dir_up_q;
        done_d     = 1'b0;
        // Address uses the pre-edge anim/frame with the coordinates of this edge.
        rom_addr_d = {anim_q, frame_q, ram_addr_y, ram_addr_x};

        if (start) begin
            state_d    = S_PLAY;
            anim_d     = anim_sel;
            len_d      = anim_len;
            mode_d     = mode;
            hold_d     = hold;
            hold_cnt_d = '0;
            dir_up_d   = 1'b1;
            frame_d    = (mode == c_MODE_REV) ? anim_len : c_F_ZERO;
        end else if (state_q == S_PLAY && tick && !pause) begin
            if (hold_cnt_q < hold_q) begin
                hold_cnt_d = hold_cnt_q + c_H_ONE;
            end else begin
                hold_cnt_d = '0;
                case (mode_q)
                    c_MODE_LOOP: begin
                        frame_d = (frame_q == len_q) ? c_F_ZERO : frame_q + c_F_ONE;
                    end
                    c_MODE_ONE: begin
                        if (frame_q == len_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            frame_d = frame_q + c_F_ONE;
                        end
                    end
                    c_MODE_PING: begin
                        // A single-frame animation has nowhere to bounce to.
                        if (len_q == c_F_ZERO) begin
                            frame_d = c_F_ZERO;
                        end else if (dir_up_q) begin
                            if (frame_q == len_q) begin
                                dir_up_d = 1'b0;
                                frame_d  = len_q - c_F_ONE;
                            end else begin
                                frame_d = frame_q + c_F_ONE;
                            end
                        end else begin
                            if (frame_q == c_F_ZERO) begin
                                dir_up_d = 1'b1;
                                frame_d  = c_F_ONE;
                            end else begin
                                frame_d = frame_q - c_F_ONE;
                            end
                        end
                    end
                    default: begin
                        frame_d = (frame_q == c_F_ZERO) ? len_q : frame_q - c_F_ONE;
                    end
                endcase
            end
        end
    end

    assign frame    = frame_q;
    assign anim_cur = anim_q;
    assign busy     = (state_q == S_PLAY);
    assign done     = done_q;
    assign rom_addr = rom_addr_q;

endmodule
`default_nettype wire

// File: doc/anim_sequencer.md
# anim_sequencer

Parametrised sprite-animation sequencer for the PMO display path. It replaces the fixed 16-step idle counter with a per-animation sequencer that supports:
- selectable animation bank and programmable frame count
- per-frame hold time and four play modes
- start/pause control and a completion pulse

It produces a registered sprite-ROM address, {animation, frame, y, x}, that feeds the animation memory directly.

## Interface
- FRAME_W, 4: frame index width; an animation has at most 2^FRAME_W frames.
- ANIM_W, 2: animation-select width (2^ANIM_W animations).
- HOLD_W, 4: hold-counter width.
- ADDR_W, 8: pixel coordinate width (x and y).
- clk_25  in  1  block clock.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  frame-time enable. Sequencing advances only on cycles with tick=1.
- start  in  1  launch/restart pulse. Latches anim_sel, anim_len, mode and hold.
- pause  in  1  level. While high, ticks are ignored; state and frame are held.
- anim_sel  in  ANIM_W  animation bank to play.
- anim_len  in  FRAME_W  last frame index (frame count − 1).
- mode  in  2  play mode: 00 loop, 01 one-shot, 10 ping-pong, 11 reverse loop.
- hold  in  HOLD_W  extra ticks per frame. Each frame is shown for hold+1 ticks.
- ram_addr_x  in  ADDR_W  pixel x from the VGA pipeline.
- ram_addr_y  in  ADDR_W  pixel y from the VGA pipeline.
- frame  out  FRAME_W  current frame index (registered).
- anim_cur  out  ANIM_W  latched animation (registered).
- busy  out  1  high in PLAY.
- done  out  1  one-cycle pulse on one-shot completion.
- rom_addr  out  ANIM_W+FRAME_W+2*ADDR_W  registered {anim_cur, frame, ram_addr_y, ram_addr_x}.

## Operation
- States: IDLE, PLAY, DONE.
- Reset values:
  - state IDLE
  - frame 0, anim_cur 0, direction up, hold_cnt 0
  - busy 0, done 0, rom_addr 0
- start (any state) → PLAY:
  - latch anim_sel → anim_cur, plus anim_len, mode and hold into internal registers
  - hold_cnt ← 0
  - frame ← 0 and direction up; in mode 11, frame ← anim_len
  - start has priority over tick and pause in the same cycle.
- PLAY, tick=1, pause=0:
  - if hold_cnt < hold_latched: hold_cnt ← hold_cnt+1.
  - otherwise: hold_cnt ← 0 and the frame advances per mode.
- Frame advance per mode:
  - loop (00): frame==len → 0, else frame+1.
  - one-shot (01): frame==len → frame held, state DONE, done=1 for exactly one cycle; else frame+1.
  - ping-pong (10):
    - going up at len → direction down, frame len−1.
    - going down at 0 → direction up, frame 1.
    - otherwise ±1 per direction.
    - len==0 → frame stays 0.
  - reverse loop (11): frame==0 → len, else frame−1.
- IDLE and DONE ignore tick and pause. frame and anim_cur hold their last values, so DONE keeps showing the last frame.
- Latched parameters do not change during play. Changing anim_sel, anim_len, mode or hold mid-play has no effect until the next start.
- All frame arithmetic is modulo 2^FRAME_W, and a frame never exceeds the latched len.
- busy = (state==PLAY).

## Timing
- Cycle-to-cycle:
  - A start at edge k gives busy=1 and the initial frame after edge k.
  - The first advance happens after hold+1 qualifying ticks. These are ticks sampled at edges after k.
- done is asserted on the cycle following the edge that enters DONE. It deasserts on the next edge.
- rom_addr has one-cycle latency. After edge k it equals {anim_cur, frame, y, x}, where:
  - anim_cur and frame are the register values just before edge k;
  - x and y are the input values sampled at edge k.
- rst mid-play: the next edge applies the reset values unconditionally, including done=0. rst has priority over start.
- tick is sampled every clk_25 edge. A tick held high for N cycles counts as N ticks.

## Test plan
- Reset:
  - Stimulus: rst=1 for 2 cycles with tick=1 and start=0.
  - Required: frame=0, busy=0, done=0, rom_addr=0. tick is ignored in IDLE.
- Loop with wrap:
  - Stimulus: anim_sel=2, len=15, mode=00, hold=0, start, then tick=1 continuously.
  - Required: frame 0,1,…,15,0,1, anim_cur=2, and rom_addr[MSBs]={2,frame} one cycle later.
- One-shot:
  - Stimulus: len=3, mode=01, hold=1, start, then continuous ticks.
  - Required: each frame is held 2 ticks. After the 8th tick, state is DONE with frame=3 held, a single-cycle done pulse, and busy=0.
- Ping-pong and reverse loop:
  - Stimulus: ping-pong with len=2 and hold=0.
  - Required: frame sequence 0,1,2,1,0,1,2.
  - Stimulus: reverse loop with len=3.
  - Required: frame sequence 3,2,1,0,3.
- Pause and restart:
  - Stimulus: in loop mode at frame 5, assert pause for 4 ticks, then release.
  - Required: frame stays 5 during pause, then goes 6.
  - Stimulus: start with anim_sel=1 and tick in the same cycle.
  - Required: frame=0, anim_cur=1, hold_cnt=0 (the tick does not advance).
- Reset mid-play:
  - Stimulus: assert rst while in PLAY at frame 7, in the same cycle as start.
  - Required: next cycle shows IDLE, frame=0, busy=0. The start is ignored.
